// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the fully-connected layer stream feeder.
// Holds the sequencer state enum, the default datapath width and the
// address-width helpers used to size memory address ports.
package fc_pkg;

  localparam int FC_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    DRAIN,
    WRITE,
    DONE
  } fc_state_t;

  // Address width for a memory of 'depth' entries; never narrower than 1 bit
  // so single-entry memories still get a legal port.
  function automatic int fc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // True when 'depth' entries are addressable with 'width' bits.
  function automatic bit fc_fits(input int depth, input int width);
    return depth <= (1 << width);
  endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// fc_addr_gen: input index j / neuron index k counters and weight address k*N+j.
// Latency: counters update on the clock edge; w_addr is combinational from them.
// Backpressure: none; the FSM drives clear/increment strobes directly.
// Ports: CLK, RST_N; clr_k/inc_k, clr_j/inc_j control strobes;
//        j, k, w_addr address outputs; last_j/last_k terminal-count flags.
module fc_addr_gen import fc_pkg::*; #(
  parameter int N  = 32,
  parameter int M  = 10,
  parameter int AW = fc_addr_w(N),
  parameter int WW = fc_addr_w(N * M),
  parameter int RW = fc_addr_w(M)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clr_k,
  input  logic          inc_k,
  input  logic          clr_j,
  input  logic          inc_j,
  output logic [AW-1:0] j,
  output logic [RW-1:0] k,
  output logic [WW-1:0] w_addr,
  output logic          last_j,
  output logic          last_k
);

  // The flattened weight memory must be fully addressable.
  if (!fc_fits(N * M, WW)) begin : g_ww_check
    $error("fc_addr_gen: WW too narrow for N*M weights");
  end

  assign last_j = (j == AW'(N - 1));
  assign last_k = (k == RW'(M - 1));
  assign w_addr = WW'(k) * WW'(N) + WW'(j);

  // Counters saturate at their terminal value so addresses stay in range
  // while the FSM waits in later states.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      j <= '0;
      k <= '0;
    end else begin
      if (clr_j)                j <= '0;
      else if (inc_j && !last_j) j <= j + AW'(1);
      if (clr_k)                k <= '0;
      else if (inc_k && !last_k) k <= k + RW'(1);
    end
  end

endmodule

// File: rtl/fc_stream_feeder.sv
// fc_stream_feeder: sequences M neurons x N operand pairs into an FC accumulate node.
// Latency: start@t -> node_clr@t+1, node_E t+3..t+2+N; per neuron 1+N+D+1 cycles.
// Backpressure: none on the stream; waits in DRAIN for node_valid; start ignored when busy.
// Ports: CLK, RST_N, start/busy/done control; act/w/b memory address+data
//        (1-cycle read latency); node_* operand stream and result handshake;
//        res_we/res_addr/res_data result-buffer write port.
module fc_stream_feeder import fc_pkg::*; #(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int N          = 32,
  parameter int M          = 10,
  parameter int AW         = fc_addr_w(N),
  parameter int WW         = fc_addr_w(N * M),
  parameter int RW         = fc_addr_w(M)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         act_addr,
  input  logic [DATA_WIDTH-1:0] act_data,
  output logic [WW-1:0]         w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [RW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  node_clr,
  output logic                  node_E,
  output logic [DATA_WIDTH-1:0] node_IN,
  output logic [DATA_WIDTH-1:0] node_RAM,
  output logic [DATA_WIDTH-1:0] node_bias,
  input  logic                  node_valid,
  input  logic [DATA_WIDTH-1:0] node_OUT,
  output logic                  res_we,
  output logic [RW-1:0]         res_addr,
  output logic [DATA_WIDTH-1:0] res_data
);

  fc_state_t     state;
  logic [AW-1:0] j;
  logic [RW-1:0] k;
  logic          last_j;
  logic          last_k;
  logic          clr_k;
  logic          inc_k;
  logic          clr_j;
  logic          inc_j;

  assign clr_k = (state == IDLE) && start;
  assign inc_k = (state == WRITE);
  assign clr_j = (state == CLR);
  assign inc_j = (state == STREAM);

  fc_addr_gen #(
    .N  (N),
    .M  (M),
    .AW (AW),
    .WW (WW),
    .RW (RW)
  ) u_addr_gen (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clr_k  (clr_k),
    .inc_k  (inc_k),
    .clr_j  (clr_j),
    .inc_j  (inc_j),
    .j      (j),
    .k      (k),
    .w_addr (w_addr),
    .last_j (last_j),
    .last_k (last_k)
  );

  assign act_addr = j;

  // The memories' output registers are the operand pipeline stage: data for
  // the address issued last cycle lines up with the registered node_E. Gating
  // keeps the operand buses at zero whenever no pair is being presented.
  assign node_IN  = act_data & {DATA_WIDTH{node_E}};
  assign node_RAM = w_data   & {DATA_WIDTH{node_E}};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      node_clr  <= 1'b0;
      node_E    <= 1'b0;
      node_bias <= '0;
      b_addr    <= '0;
      res_we    <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
    end else begin
      node_clr <= 1'b0;
      node_E   <= 1'b0;
      res_we   <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLR;
            busy     <= 1'b1;
            node_clr <= 1'b1;
            b_addr   <= '0;
          end
        end
        CLR: begin
          state <= STREAM;
        end
        STREAM: begin
          node_E <= 1'b1;
          // Bias read was issued in CLR, so it lands on the first STREAM cycle.
          if (j == '0) node_bias <= b_data;
          if (last_j) state <= DRAIN;
        end
        DRAIN: begin
          if (node_valid) begin
            res_data <= node_OUT;
            res_addr <= k;
            res_we   <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (last_k) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= CLR;
            node_clr <= 1'b1;
            b_addr   <= k + RW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_stream_feeder.sv
// tb_fc_stream_feeder: self-checking bench for fc_stream_feeder (N=4, M=2).
// Behavioural memories and a latency-programmable accumulate node surround
// the DUT; expectations come from a per-pass cycle timeline and dot products.
module tb_fc_stream_feeder;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int M  = 2;
  localparam int AW = 2;
  localparam int WW = 3;
  localparam int RW = 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] act_addr;
  logic [DW-1:0] act_data;
  logic [WW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [RW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          node_clr;
  logic          node_E;
  logic [DW-1:0] node_IN;
  logic [DW-1:0] node_RAM;
  logic [DW-1:0] node_bias;
  logic          node_valid;
  logic [DW-1:0] node_OUT;
  logic          res_we;
  logic [RW-1:0] res_addr;
  logic [DW-1:0] res_data;

  fc_stream_feeder #(
    .DATA_WIDTH (DW), .N (N), .M (M), .AW (AW), .WW (WW), .RW (RW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .act_addr   (act_addr),
    .act_data   (act_data),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .node_clr   (node_clr),
    .node_E     (node_E),
    .node_IN    (node_IN),
    .node_RAM   (node_RAM),
    .node_bias  (node_bias),
    .node_valid (node_valid),
    .node_OUT   (node_OUT),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_data   (res_data)
  );

  always #5 CLK = ~CLK;

  // Synchronous read memories, one cycle of latency.
  logic [DW-1:0] act_mem [N];
  logic [DW-1:0] w_mem   [N*M];
  logic [DW-1:0] b_mem   [M];

  always @(posedge CLK) begin
    act_data <= act_mem[act_addr];
    w_data   <= w_mem[w_addr];
    b_data   <= b_mem[b_addr];
  end

  // Accumulate node: result is acc + bias (+ the pair on the bus right now),
  // valid D cycles into DRAIN (D>=2), always high in d0 mode, and optionally
  // pulsed spuriously on the first two STREAM cycles with a partial sum.
  int            d_lat = 3;
  bit            d0_mode = 1'b0;
  bit            spur_en = 1'b0;
  logic [DW-1:0] acc = '0;
  int            since_e = 100;
  bit            armed = 1'b0;
  logic          clr_d1 = 1'b0;
  logic          clr_d2 = 1'b0;

  always @(posedge CLK) begin
    if (node_clr) begin
      acc   <= '0;
      armed <= 1'b0;
    end else if (node_E) begin
      acc   <= acc + node_IN * node_RAM;
      armed <= 1'b1;
    end
    since_e <= node_E ? 0 : since_e + 1;
    clr_d1  <= node_clr;
    clr_d2  <= clr_d1;
  end

  assign node_OUT   = acc + node_bias + (node_E ? node_IN * node_RAM : '0);
  assign node_valid = d0_mode || (spur_en && (clr_d1 || clr_d2)) ||
                      (armed && !node_E && since_e == d_lat - 2);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input int kk);
    logic [DW-1:0] s;
    s = b_mem[kk];
    for (int jj = 0; jj < N; jj++) s = s + act_mem[jj] * w_mem[kk*N + jj];
    return s;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, node_clr, node_E, res_we,
                        act_addr, w_addr, b_addr, res_addr}, '0);
    chk({tag, "_dat"}, {32'h0, node_IN | node_RAM | node_bias | res_data}, '0);
  endtask

  // One layer pass. dl = node latency (0 => valid held high), spur = spurious
  // valid in STREAM, xstart = extra start pulses while busy, rst_at = relative
  // cycle at which reset is dropped (0 = never).
  task automatic run_pass(input int dl, input bit spur, input bit xstart, input int rst_at);
    int deff, p, kk, ph, last;
    logic [DW-1:0] expr [M];
    logic [4:0] ctl;
    d_lat   = dl;
    d0_mode = (dl == 0);
    spur_en = spur;
    deff    = (dl == 0) ? 1 : dl;
    p       = N + 2 + deff;
    last    = M * p;
    for (int i = 0; i < M; i++) expr[i] = ref_result(i);
    @(negedge CLK);
    start = 1'b1;
    for (int rel = 1; rel <= last + 1; rel++) begin
      @(negedge CLK);
      start = 1'b0;
      kk = (rel - 1) / p;
      ph = (rel - 1) % p;
      if (rel == rst_at) begin
        RST_N = 1'b0;
        #1;
        chk_all_zero("midrst");
        for (int c = 0; c < 3; c++) begin
          @(negedge CLK);
          chk("midrst_hold", {busy, res_we, done}, '0);
        end
        RST_N = 1'b1;
        d0_mode = 1'b0;
        spur_en = 1'b0;
        return;
      end
      ctl[4] = (rel <= last);
      ctl[3] = (rel == last + 1);
      ctl[2] = (rel <= last) && (ph == 0);
      ctl[1] = (rel <= last) && (ph >= 2) && (ph <= N + 1);
      ctl[0] = (rel <= last) && (ph == p - 1);
      chk("ctl_busy_done_clr_E_we", {busy, done, node_clr, node_E, res_we}, ctl);
      if (rel <= last && ph >= 1 && ph <= N) begin
        chk("w_addr", w_addr, kk * N + ph - 1);
        chk("act_addr", act_addr, ph - 1);
      end
      if (ctl[1]) begin
        chk("node_IN", node_IN, act_mem[ph-2]);
        chk("node_RAM", node_RAM, w_mem[kk*N + ph - 2]);
        chk("node_bias", node_bias, b_mem[kk]);
      end
      if (ctl[0]) begin
        chk("res_addr", res_addr, kk);
        chk("res_data", res_data, expr[kk]);
      end
      if (xstart && rel <= last && (ph == 3 || ph == N + 1)) start = 1'b1;
    end
    // Nothing further after done: no extra writes, no second done.
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("post_idle", {busy, done, node_clr, node_E, res_we}, '0);
    end
    d0_mode = 1'b0;
    spur_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++)     act_mem[i] = i + 1;
    for (int i = 0; i < N * M; i++) w_mem[i]   = i + 1;
    b_mem[0] = 10;
    b_mem[1] = 20;

    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    // Directed data set: reference results must be 40 and 90.
    chk("ref_k0", ref_result(0), 40);
    chk("ref_k1", ref_result(1), 90);
    RST_N = 1'b1;
    @(negedge CLK);

    run_pass(3, 1'b0, 1'b0, 0);            // baseline, D=3
    run_pass(3, 1'b0, 1'b1, 0);            // start during STREAM/DRAIN ignored
    run_pass(2, 1'b1, 1'b0, 0);            // spurious valid in STREAM
    run_pass(3, 1'b0, 1'b0, (N + 5) + 4);  // reset in 2nd neuron STREAM
    run_pass(3, 1'b0, 1'b0, 0);            // fresh pass after reset
    run_pass(0, 1'b0, 1'b0, 0);            // zero-latency node

    for (int r = 0; r < 8; r++) begin
      int dsel;
      for (int i = 0; i < N; i++)     act_mem[i] = $urandom;
      for (int i = 0; i < N * M; i++) w_mem[i]   = $urandom;
      for (int i = 0; i < M; i++)     b_mem[i]   = $urandom;
      dsel = $urandom_range(0, 4);
      run_pass((dsel == 0) ? 0 : dsel + 1, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fc_stream_feeder.md
# fc_stream_feeder

Sequencer that drives a fully-connected layer node. For each of M neurons it reads N activations and N weights from synchronous memories and streams them as multiplier operand pairs with an enable strobe, supplying that neuron's bias. It then waits for the node's result-valid and writes the finished output into a result buffer. It sits between the activation/weight/bias memories and the FC accumulate node, and is the producer side of the node's IN/RAM/bias/E stream.

## Interface
Parameters:
- DATA_WIDTH, 32, width of activations, weights, bias, results
- N, 32, inputs per neuron (stream length)
- M, 10, neurons per layer
- AW, $clog2(N), activation address width
- WW, $clog2(N*M), weight address width
- RW, $clog2(M), bias/result address width

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a layer pass when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result write
- act_addr  out  AW  activation read address
- act_data  in  DATA_WIDTH  activation read data, 1-cycle latency
- w_addr  out  WW  weight read address
- w_data  in  DATA_WIDTH  weight read data, 1-cycle latency
- b_addr  out  RW  bias read address
- b_data  in  DATA_WIDTH  bias read data, 1-cycle latency
- node_clr  out  1  accumulator clear, one cycle before each neuron's stream
- node_E  out  1  operand-pair valid
- node_IN  out  DATA_WIDTH  activation operand
- node_RAM  out  DATA_WIDTH  weight operand
- node_bias  out  DATA_WIDTH  bias for the current neuron; held until its result is written
- node_valid  in  1  node result valid
- node_OUT  in  DATA_WIDTH  node result
- res_we  out  1  result write strobe
- res_addr  out  RW  result index (neuron number)
- res_data  out  DATA_WIDTH  result value

## Operation
- FSM states: IDLE, CLR, STREAM, DRAIN, WRITE, DONE.
- IDLE: start=1 -> CLR, and neuron counter k=0.
- CLR (1 cycle):
  - node_clr=1, b_addr=k.
  - j=0.
  - Transitions to STREAM.
- STREAM (N cycles):
  - Issue act_addr=j and w_addr=k*N+j; j increments each cycle.
  - Registered node_E, node_IN, node_RAM follow addresses by 1 cycle, so node_E is high for exactly N consecutive cycles.
  - node_bias is captured from b_data on the first STREAM cycle.
  - After j=N-1 is issued -> DRAIN.
- DRAIN:
  - Wait for node_valid=1.
  - Capture node_OUT into res_data; -> WRITE.
- WRITE (1 cycle):
  - res_we=1, res_addr=k.
  - If k==M-1 -> DONE; else k++ -> CLR.
- DONE (1 cycle): done=1 -> IDLE.
- start while not IDLE: ignored, no queuing.
- node_valid outside DRAIN: ignored.
- Arithmetic: weight address computed as k*N+j in WW bits; N*M must fit WW, checked at elaboration.

## Timing
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- Reset asserted mid-pass:
  - Immediate return to IDLE, all outputs 0.
  - No partial result write, no done pulse.
- start at cycle t (IDLE) -> busy=1 and node_clr=1 at t+1.
- First node_E at t+3; last node_E at t+2+N.
- Per-neuron cost: 1 (CLR) + N (STREAM) + D (DRAIN, node latency) + 1 (WRITE) cycles.
- res_we is exactly one cycle per neuron, in ascending res_addr order 0..M-1.
- done asserts the cycle after the final res_we; busy drops in the same cycle as done.
- node_clr and node_E are never simultaneously high.

## Structure
- Shared package fc_pkg holds:
  - the FSM state enum
  - DATA_WIDTH default
  - address-width helper functions
- One natural sub-module: fc_addr_gen, containing the j/k counters and the weight address multiply-add. It exposes last_j and last_k flags to the FSM.
- Operand output registers and the FSM stay in the top level.

## Test plan
- N=4, M=2. Activations 1,2,3,4; weights 1..8; biases 10,20; behavioral node model with D=3.
  - res_data=40 at addr 0.
  - res_data=90 at addr 1.
  - done one cycle after the second res_we.
- start at cycle t:
  - node_clr at t+1.
  - node_E high exactly cycles t+3..t+6.
  - w_addr sequence 0,1,2,3 then 4,5,6,7.
- start pulsed during STREAM and during DRAIN:
  - no effect.
  - exactly M res_we pulses.
  - one done.
- RST_N dropped during second neuron's STREAM:
  - all outputs 0 immediately.
  - no res_we for addr 1.
  - a fresh start afterwards completes normally.
- Spurious node_valid during STREAM:
  - ignored.
  - the result is captured only on the node_valid in DRAIN.
- Node latency D=0 (node_valid already high on entering DRAIN):
  - DRAIN lasts 1 cycle.
  - throughput matches N+3 cycles per neuron.
